// File: rtl/word_burst_selector.sv
// word_burst_selector: snapshots NUM_IN wide sources on a burst request and
// streams a contiguous, wrapping run of OUT_WIDTH words over valid/ready.
// Word k is source k/R, sub-word k%R, with the most significant word first.
module word_burst_selector #(
    parameter  int NUM_IN    = 3,
    parameter  int IN_WIDTH  = 64,
    parameter  int OUT_WIDTH = 32,
    localparam int R         = IN_WIDTH / OUT_WIDTH,
    localparam int NUM_WORDS = NUM_IN * R,
    localparam int SEL_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int LEN_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN*IN_WIDTH-1:0]  in_data,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [SEL_W-1:0]            start_sel,
    input  logic [LEN_W-1:0]            start_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err
);

    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    state_t                      state, state_next;
    logic [NUM_IN*IN_WIDTH-1:0]  snapshot;
    logic [SEL_W-1:0]            cur;
    logic [LEN_W-1:0]            remaining;
    logic                        req_ok;
    logic                        accept;
    logic                        fire;
    logic                        last_beat;

    // Extract word k from the flattened snapshot; upper sub-word comes first.
    function automatic logic [OUT_WIDTH-1:0] word_at(
        input logic [NUM_IN*IN_WIDTH-1:0] src,
        input logic [SEL_W-1:0]           k
    );
        int base;
        base = (int'(k) / R) * IN_WIDTH + IN_WIDTH - 1 - (int'(k) % R) * OUT_WIDTH;
        return src[base -: OUT_WIDTH];
    endfunction

    assign req_ok    = (int'(start_sel) < NUM_WORDS) && (start_len != '0) &&
                       (int'(start_len) <= NUM_WORDS);
    assign last_beat = (remaining == LEN_W'(1));

    assign start_ready = (state == IDLE);
    assign out_valid   = (state == STREAM);
    assign busy        = (state == STREAM);
    assign out_data    = word_at(snapshot, cur);
    assign out_index   = cur;
    assign out_last    = (state == STREAM) && last_beat;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept a legal request in IDLE, leave STREAM after the last handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid && req_ok) begin
                    accept     = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    fire = 1'b1;
                    if (last_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst bookkeeping: snapshot on accept, advance the wrapping word pointer per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot  <= '0;
            cur       <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            err <= (state == IDLE) && start_valid && !req_ok;
            if (accept) begin
                snapshot  <= in_data;
                cur       <= start_sel;
                remaining <= start_len;
            end else if (fire && !last_beat) begin
                cur       <= (int'(cur) == NUM_WORDS - 1) ? '0 : cur + SEL_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_burst_selector.sv
// Testbench for word_burst_selector: directed scenarios plus randomized bursts
// checked against a queue-based reference model of the word stream.
module tb_word_burst_selector;

    localparam int NUM_IN    = 3;
    localparam int IN_WIDTH  = 64;
    localparam int OUT_WIDTH = 32;
    localparam int NUM_WORDS = 6;
    localparam int SEL_W     = 3;
    localparam int LEN_W     = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_IN*IN_WIDTH-1:0]  in_data;
    logic                        start_valid;
    logic                        start_ready;
    logic [SEL_W-1:0]            start_sel;
    logic [LEN_W-1:0]            start_len;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]            out_index;
    logic                        out_last;
    logic                        busy;
    logic                        err;

    int checks   = 0;
    int failures = 0;

    logic [63:0] src_m [NUM_IN];

    typedef struct {
        logic [31:0] data;
        int          index;
        logic        last;
    } beat_t;

    beat_t exp_q [$];

    word_burst_selector #(
        .NUM_IN(NUM_IN), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_sel(start_sel), .start_len(start_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sources();
        for (int i = 0; i < NUM_IN; i++) in_data[i*64 +: 64] = src_m[i];
    endtask

    task automatic default_sources();
        src_m[0] = 64'h1111_1111_2222_2222;
        src_m[1] = 64'h3333_3333_4444_4444;
        src_m[2] = 64'h5555_5555_6666_6666;
        load_sources();
    endtask

    // Reference word: source k/2, upper half for even k.
    function automatic logic [31:0] ref_word(int k);
        logic [63:0] s;
        s = src_m[k / 2];
        return (k % 2 == 0) ? s[63:32] : s[31:0];
    endfunction

    // Present a request for one edge; DUT is in STREAM afterwards if it was legal.
    task automatic issue(int sel, int len);
        start_sel   = SEL_W'(sel);
        start_len   = LEN_W'(len);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, out_data, out_index, out_last, start_ready, busy, err} !==
            {1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: valid=%0b data=%h idx=%0d last=%0b rdy=%0b busy=%0b err=%0b expected 0,0,0,0,1,0,0",
                     out_valid, out_data, out_index, out_last, start_ready, busy, err);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        issue(1, 1);
        checks++;
        if ({out_valid, out_data, out_index, out_last, busy} !== {1'b1, 32'h2222_2222, 3'd1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_beat: valid=%0b data=%h idx=%0d last=%0b busy=%0b expected 1 22222222 1 1 1",
                     out_valid, out_data, out_index, out_last, busy);
        end
        step();
        checks++;
        if ({out_valid, start_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL single_end: valid=%0b rdy=%0b busy=%0b expected 0 1 0", out_valid, start_ready, busy);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        int          exp_i [4];
        exp_d[0] = 32'h5555_5555; exp_d[1] = 32'h6666_6666;
        exp_d[2] = 32'h1111_1111; exp_d[3] = 32'h2222_2222;
        exp_i[0] = 4; exp_i[1] = 5; exp_i[2] = 0; exp_i[3] = 1;
        out_ready = 1'b1;
        issue(4, 4);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if ({out_valid, out_data, out_index, out_last} !==
                {1'b1, exp_d[b], SEL_W'(exp_i[b]), (b == 3)}) begin
                failures++;
                $display("FAIL wrap_beat%0d: valid=%0b data=%h idx=%0d last=%0b expected 1 %h %0d %0b",
                         b, out_valid, out_data, out_index, out_last, exp_d[b], exp_i[b], (b == 3));
            end
            step();
        end
        checks++;
        if ({out_valid, start_ready} !== 2'b01) begin
            failures++;
            $display("FAIL wrap_end: valid=%0b rdy=%0b expected 0 1", out_valid, start_ready);
        end
    endtask

    task automatic test_stall_snapshot();
        logic [31:0] exp_d [6];
        exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h3333_3333 ^ 32'h0000_0000;
        exp_d[1] = 32'h2222_2222;
        exp_d[2] = 32'h3333_3333; exp_d[3] = 32'h4444_4444;
        exp_d[4] = 32'h5555_5555; exp_d[5] = 32'h6666_6666;
        out_ready = 1'b1;
        issue(0, 6);
        in_data = '1;
        for (int b = 0; b < 6; b++) begin
            if (b == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    checks++;
                    if ({out_valid, out_data, out_index, out_last} !== {1'b1, 32'h3333_3333, 3'd2, 1'b0}) begin
                        failures++;
                        $display("FAIL stall_hold%0d: valid=%0b data=%h idx=%0d last=%0b expected 1 33333333 2 0",
                                 s, out_valid, out_data, out_index, out_last);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if ({out_valid, out_data, out_index, out_last} !== {1'b1, exp_d[b], SEL_W'(b), (b == 5)}) begin
                failures++;
                $display("FAIL stall_beat%0d: valid=%0b data=%h idx=%0d last=%0b expected 1 %h %0d %0b",
                         b, out_valid, out_data, out_index, out_last, exp_d[b], b, (b == 5));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: valid=%0b expected 0", out_valid);
        end
        default_sources();
    endtask

    task automatic test_invalid();
        int sels [3];
        int lens [3];
        sels[0] = 6; lens[0] = 2;
        sels[1] = 0; lens[1] = 0;
        sels[2] = 0; lens[2] = 7;
        for (int t = 0; t < 3; t++) begin
            issue(sels[t], lens[t]);
            checks++;
            if ({err, out_valid, start_ready, busy} !== 4'b1010) begin
                failures++;
                $display("FAIL invalid%0d_pulse: err=%0b valid=%0b rdy=%0b busy=%0b expected 1 0 1 0",
                         t, err, out_valid, start_ready, busy);
            end
            step();
            checks++;
            if ({err, out_valid, start_ready} !== 3'b001) begin
                failures++;
                $display("FAIL invalid%0d_after: err=%0b valid=%0b rdy=%0b expected 0 0 1",
                         t, err, out_valid, start_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(2, 3);
        step();
        checks++;
        if ({out_valid, out_data, out_index} !== {1'b1, 32'h4444_4444, 3'd3}) begin
            failures++;
            $display("FAIL rstmid_beat2: valid=%0b data=%h idx=%0d expected 1 44444444 3", out_valid, out_data, out_index);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, busy, start_ready, out_last} !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_abort: valid=%0b busy=%0b rdy=%0b last=%0b expected 0 0 1 0",
                     out_valid, busy, start_ready, out_last);
        end
        issue(5, 1);
        checks++;
        if ({out_valid, out_data, out_index, out_last} !== {1'b1, 32'h6666_6666, 3'd5, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_fresh: valid=%0b data=%h idx=%0d last=%0b expected 1 66666666 5 1",
                     out_valid, out_data, out_index, out_last);
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int    sel;
            int    len;
            int    cyc;
            logic  hs;
            for (int i = 0; i < NUM_IN; i++) src_m[i] = {$urandom(), $urandom()};
            load_sources();
            sel = $urandom_range(0, NUM_WORDS - 1);
            len = $urandom_range(1, NUM_WORDS);
            exp_q.delete();
            for (int i = 0; i < len; i++) begin
                beat_t bt;
                bt.data  = ref_word((sel + i) % NUM_WORDS);
                bt.index = (sel + i) % NUM_WORDS;
                bt.last  = (i == len - 1);
                exp_q.push_back(bt);
            end
            issue(sel, len);
            cyc = 0;
            while ((exp_q.size() > 0 || out_valid) && cyc < 100) begin
                checks++;
                if (out_valid !== (exp_q.size() > 0)) begin
                    failures++;
                    $display("FAIL rand%0d_valid: valid=%0b expected %0b", n, out_valid, (exp_q.size() > 0));
                end
                if (exp_q.size() > 0) begin
                    checks++;
                    if ({out_data, out_index, out_last} !==
                        {exp_q[0].data, SEL_W'(exp_q[0].index), exp_q[0].last}) begin
                        failures++;
                        $display("FAIL rand%0d_beat: data=%h idx=%0d last=%0b expected %h %0d %0b",
                                 n, out_data, out_index, out_last, exp_q[0].data, exp_q[0].index, exp_q[0].last);
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
                in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                hs        = out_valid && out_ready;
                step();
                if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
                cyc++;
            end
            checks++;
            if (cyc >= 100) begin
                failures++;
                $display("FAIL rand%0d_timeout: cycles=%0d expected burst completion below 100", n, cyc);
            end
        end
        default_sources();
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        start_sel   = '0;
        start_len   = '0;
        out_ready   = 1'b0;
        default_sources();
        test_reset();
        test_single();
        test_wrap();
        test_stall_snapshot();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_burst_selector.md
Name: word_burst_selector

Overview:
- Parametrised successor to the fixed 9-way 32-bit result selector.
- Holds NUM_IN wide source values, each IN_WIDTH bits, for example 64-bit HI/LO and mult/div results.
- Each source is split into OUT_WIDTH words, and any contiguous run of words (with wrap-around) is streamed out over a valid/ready handshake.
- Sits between the wide-result datapath and the 32-bit writeback/debug bus. A snapshot of the sources is taken at start, so the sources may change during a burst.

Parameters:
- NUM_IN, 3, number of wide source inputs.
- IN_WIDTH, 64, width of each source; must be a multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output word width.
- Derived, not overridable:
  - R = IN_WIDTH/OUT_WIDTH.
  - NUM_WORDS = NUM_IN*R (6 by default).
  - SEL_W = clog2(NUM_WORDS).
  - LEN_W = clog2(NUM_WORDS+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  NUM_IN*IN_WIDTH  source i occupies bits [(i+1)*IN_WIDTH-1 : i*IN_WIDTH]
- start_valid  in  1  burst request
- start_ready  out  1  block can accept a request
- start_sel  in  SEL_W  first word index
- start_len  in  LEN_W  number of words, 1..NUM_WORDS
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- out_data  out  OUT_WIDTH  selected word
- out_index  out  SEL_W  word index of out_data
- out_last  out  1  final word of burst
- busy  out  1  burst in progress
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Word mapping: word k = source k/R, sub-word j = k%R. Data bits are [IN_WIDTH-1-j*OUT_WIDTH -: OUT_WIDTH], i.e. the upper half comes first (word 0 = source0[63:32]).
- Reset values (rst high at a clock edge; dominates everything):
  - state = IDLE.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0.
  - busy = 0, err = 0.
  - start_ready = 1.
  - Snapshot register = 0.
- States: IDLE and STREAM.
- start_ready = (state == IDLE), driven combinationally from the state register.
- IDLE:
  - On start_valid with start_sel < NUM_WORDS and 1 <= start_len <= NUM_WORDS, the request is accepted:
    - snapshot <= in_data, cur <= start_sel, remaining <= start_len.
    - Go to STREAM; the first word is presented registered on the next cycle (latency 1).
  - On start_valid with an invalid sel or len:
    - err = 1 for exactly one cycle.
    - Stay in IDLE; out_valid stays 0.
- STREAM:
  - out_valid = 1, busy = 1.
  - out_data = word[cur] taken from the snapshot; out_index = cur; out_last = (remaining == 1).
- Backpressure: while out_ready = 0, out_data, out_index and out_last hold stable and out_valid stays 1.
- On out_valid && out_ready:
  - Not last: cur <= (cur == NUM_WORDS-1) ? 0 : cur+1; remaining decrements.
  - Last: go to IDLE next cycle; out_valid = 0 and start_ready = 1 in that cycle.
- Throughput: one word per cycle with out_ready held high. Back-to-back bursts have a minimum 1-cycle gap (the IDLE accept cycle).
- start_valid while in STREAM is ignored; the requester must hold it until start_ready.
- Changing in_data after acceptance never affects the burst in progress.
- Reset mid-burst: the burst is abandoned and the block returns to IDLE/reset values at the next edge.

Test Plan:
- Sources 0..2 = 64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444, 64'h5555_5555_6666_6666 unless stated.
- Reset for 2 cycles -> out_valid=0, out_data=0, start_ready=1, busy=0, err=0.
- sel=1, len=1, out_ready=1 -> one cycle after accept: out_data=32'h2222_2222, out_index=1, out_last=1; the following cycle out_valid=0, start_ready=1.
- sel=4, len=4, out_ready=1 -> wrap-around:
  - out_data = 5555_5555, 6666_6666, 1111_1111, 2222_2222 on consecutive cycles.
  - out_index = 4, 5, 0, 1; out_last only on the 4th beat.
- sel=0, len=6, out_ready low for 3 cycles at beat 2; in_data set to all-ones mid-burst:
  - 3333_3333 held stable during the stall.
  - All six original words delivered in order; all-ones never appears.
- Invalid requests: sel=6/len=2, sel=0/len=0 and sel=0/len=7 -> err high for exactly 1 cycle each; out_valid stays 0; start_ready stays 1.
- sel=2, len=3, rst asserted at the second beat -> next cycle out_valid=0, busy=0, start_ready=1. A fresh request with sel=5, len=1 then yields 32'h6666_6666.
